// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, one-entry fetch register with ready/valid handshake, halt and branch redirect.
// Optional stall counter output is enabled by defining IFETCH_STALL_CNT_EN.
module instruction_fetch #(
    parameter int                 ADDR_W      = 8,
    parameter int                 DATA_W      = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter int                 PROG_LEN    = 6,
    parameter logic [DATA_W-1:0]  HALT_OPCODE = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] instruction_address,
    input  logic [DATA_W-1:0] instruction_data,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
`ifdef IFETCH_STALL_CNT_EN
    output logic [15:0]       stall_count,
`endif
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_instr_reg;
    logic [ADDR_W-1:0] out_pc_reg;

    logic capture;
    logic branch_take;
    logic halt_hit;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a branch always wins over a halt condition
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  state_next = ST_FETCH;
            ST_FETCH: begin
                if (branch_valid) begin
                    state_next = ST_FETCH;
                end else if (capture && halt_hit) begin
                    state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (branch_valid) begin
                    state_next = ST_FETCH;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        capture     = 1'b0;
        branch_take = 1'b0;
        halted      = 1'b0;
        if (state_reg == ST_FETCH && (!out_valid_reg || out_ready) && !branch_valid) begin
            capture = 1'b1;
        end
        if (branch_valid && state_reg != ST_IDLE) begin
            branch_take = 1'b1;
        end
        if (state_reg == ST_HALT) begin
            halted = 1'b1;
        end
    end

    // Compare at 32 bits so a PROG_LEN beyond the address space never matches
    assign halt_hit = (instruction_data == HALT_OPCODE) ||
                      (32'(pc_reg) == 32'(PROG_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg        <= RESET_PC;
            out_valid_reg <= 1'b0;
            out_instr_reg <= '0;
            out_pc_reg    <= '0;
        end else if (branch_take) begin
            pc_reg        <= branch_target;
            out_valid_reg <= 1'b0;
        end else if (capture) begin
            pc_reg        <= pc_reg + 1'b1;
            out_valid_reg <= 1'b1;
            out_instr_reg <= instruction_data;
            out_pc_reg    <= pc_reg;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    // Saturating count of edges where decode back-pressures a valid word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (out_valid_reg && !out_ready && stall_cnt_reg != 16'hFFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_count = stall_cnt_reg;
`endif

    assign instruction_address = pc_reg;
    assign out_valid           = out_valid_reg;
    assign out_instr           = out_instr_reg;
    assign out_pc              = out_pc_reg;

endmodule
